exe_muldiv_unit: RTL and testbench
==================================

# exe_muldiv_unit

Execute-stage multi-cycle multiply/divide unit owning the HI/LO register pair. It consumes the operands and control flags that the decode/execute pipeline register delivers to EX: `a`, `b`, `sign`, `HiWrite`/`LoWrite` and the mul/div select. It returns a stall to the pipeline front end while a 32-step operation is in flight. It sits beside the ALU in EX; HI/LO reads (mfhi/mflo) are served from its output registers.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `start`  in  1  mult/div instruction present in EX this cycle.
- `is_div`  in  1  1 = divide, 0 = multiply; sampled with `start`.
- `sign`  in  1  1 = signed operation; sampled with `start`.
- `a`  in  WIDTH  rs operand (multiplicand/dividend); also the mthi/mtlo data.
- `b`  in  WIDTH  rt operand (multiplier/divisor).
- `hi_write`  in  1  mthi in EX.
- `lo_write`  in  1  mtlo in EX.
- `hilo_read`  in  1  mfhi/mflo in EX.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in flight (state != IDLE).
- `stall`  out  1  combinational: `busy & (start | hi_write | lo_write | hilo_read)`.
- `done`  out  1  registered one-cycle pulse after HI/LO are updated.

## Operation
- Reset: state IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, step counter = 0.
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE:
  - `start` → PREP; operands are latched, and for signed operations converted to magnitudes with the operand signs recorded.
  - Otherwise, `hi_write` loads `hi` <= `a` and `lo_write` loads `lo` <= `a`; both may occur together.
  - `start` has priority over `hi_write`/`lo_write` in the same cycle; the writes are dropped.
- PREP → RUN, counter = 0.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add.
  - Divide: restoring subtract-shift.
  - After 32 steps (counter = 31) → FIX.
- FIX: apply sign correction, write `hi`/`lo`, → IDLE, `done` <= 1.
- Results:
  - Multiply: `{hi,lo}` = 64-bit product (signed or unsigned).
  - Divide: `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
- Divide by zero: `lo` = all ones, `hi` = original `a`, for both signed and unsigned; no exception is raised.
- Signed -2^31 / -1: `lo` = 0x80000000, `hi` = 0.
- While busy:
  - `start`, `hi_write` and `lo_write` are ignored, and `stall` is asserted so EX holds the instruction.
  - `hi`/`lo` keep their previous values until FIX.
- `clr` asserted mid-operation: immediate return to the reset state; the partial result is discarded.

## Timing
- Start accepted on edge E0. PREP occupies cycle 1, RUN cycles 2–33, FIX cycle 34.
- `hi`/`lo` are updated on edge E34, i.e. 34 cycles after acceptance.
- `busy` is high from after E0 until E34; `done` is high for the single cycle after E34.
- A held instruction re-presents `start` on the first cycle with `busy` = 0 and is accepted on that edge. Back-to-back operations therefore issue every 35 cycles.
- `stall` has no register stage; it is valid in the same cycle as its inputs.
- `hi_write`/`lo_write` accepted in IDLE are visible on `hi`/`lo` the next cycle.

## Structure
- Shared package:
  - FSM state enum (IDLE/PREP/RUN/FIX).
  - `WIDTH` default.
  - Step-count constant (32).
  - Divide-by-zero quotient constant (all ones).
- One natural sub-module, `muldiv_step`: combinational single radix-2 step. It takes the partial remainder/product, the operand and `is_div`, and returns the next partial value and quotient bit.
- The FSM, counter, sign handling and HI/LO registers stay in `exe_muldiv_unit`.

## Test plan
- Unsigned multiply 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles `hi` = 0xFFFFFFFE, `lo` = 0x00000001, `done` pulses once.
- Signed multiply −3 × 5 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1.
- Divides:
  - Unsigned 100 / 7 → `lo` = 14, `hi` = 2.
  - Signed −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- Divide by zero, 5 / 0 signed and unsigned → `lo` = 0xFFFFFFFF, `hi` = 5. Signed 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- `hi_write` with `a` = 0x1234 and `hilo_read` asserted during cycle 10 of a multiply → `stall` = 1 in those cycles, `hi` unchanged until FIX. `hi_write` in IDLE → `hi` = 0x1234 next cycle.
- `clr` pulsed at cycle 10 of a divide → `busy` = 0, `hi` = `lo` = 0, no `done`. A following unsigned 9 / 3 completes with `lo` = 3, `hi` = 0.

Source files
------------

// File: rtl/exe_muldiv_pkg.sv
// Shared types and constants for the EX-stage multi-cycle multiply/divide unit.
package exe_muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int STEPS     = 32;
  localparam int CNT_W     = $clog2(STEPS);

  localparam logic [WIDTH_DEF-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_t;

endpackage

// File: rtl/exe_muldiv_unit_muldiv_step.sv
// One radix-2 step: shift-add for multiply, restoring subtract-shift for divide.
module muldiv_step
  import exe_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;

  assign sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
  assign shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
  assign fits    = shifted >= {1'b0, opnd_i};
  // Remainder stays below the divisor, so the W-bit modular difference is exact.
  assign rem_sub = shifted[WIDTH-1:0] - opnd_i;

  // NOTE: every output gets a default before the branch so no latch is inferred.
  always_comb begin
    q_bit_o = 1'b0;
    acc_o   = {sum, acc_i[WIDTH-1:1]};
    if (is_div_i) begin
      q_bit_o = fits;
      acc_o   = {(fits ? rem_sub : shifted[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exe_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO; stalls the front end while a
// 32-step operation runs.
module exe_muldiv_unit
  import exe_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             is_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q_bit;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               div_zero_q;
  logic               done_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign mag_a = (sign && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sign && b[WIDTH-1]) ? -b : b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc),
    .q_bit_o  (step_q_bit)
  );

  // The step leaves the quotient slot clear; the new quotient bit drops in here.
  assign acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q_bit};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Divide iterates the dividend magnitude against the divisor;
            // multiply shifts the multiplier out under the multiplicand.
            acc_q      <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd_q     <= is_div ? mag_b : mag_a;
            a_q        <= a;
            is_div_q   <= is_div;
            neg_q      <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q  <= sign & a[WIDTH-1];
            div_zero_q <= (b == '0);
            state_q    <= PREP;
          end else begin
            if (hi_write) hi_q <= a;
            if (lo_write) lo_q <= a;
          end
        end
        PREP: begin
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STEPS - 1)) state_q <= FIX;
        end
        FIX: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (div_zero_q) begin
            lo_q <= DIV_ZERO_Q;
            hi_q <= a_q;
          end else begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | hi_write | lo_write | hilo_read);
  assign done  = done_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed self-checking bench for exe_muldiv_unit.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start, is_div, sign, hi_write, lo_write, hilo_read;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, stall, done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic        d;
    logic        s;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  exe_muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .is_div    (is_div),
    .sign      (sign),
    .a         (a),
    .b         (b),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .hilo_read (hilo_read),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Issues one operation and reports what came back; callers judge the results.
  task automatic run_op(input logic d, input logic s, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] rh, output logic [31:0] rl, output int lat,
                        output logic changed, output logic done_after);
    logic [31:0] h0, l0;
    @(posedge clk); #1;
    start = 1'b1; is_div = d; sign = s; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    h0 = hi; l0 = lo; lat = 0; changed = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (hi !== h0 || lo !== l0) changed = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    rh = hi; rl = lo;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset;
    #2;
    cmp_cnt++; if (hi !== 32'h0)  begin err_cnt++; $display("FAIL reset hi: got %h want 0", hi); end
    cmp_cnt++; if (lo !== 32'h0)  begin err_cnt++; $display("FAIL reset lo: got %h want 0", lo); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset busy: got %b want 0", busy); end
    cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset done: got %b want 0", done); end
    hi_write = 1'b1; a = 32'hAAAA;
    @(posedge clk); #1;
    cmp_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL reset hold hi: got %h want 0", hi); end
    hi_write = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_hilo_write;
    int n;
    @(posedge clk); #1;
    hi_write = 1'b1; a = 32'h1234;
    #1;
    cmp_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL idle stall: got %b want 0", stall); end
    @(posedge clk); #1;
    hi_write = 1'b0;
    cmp_cnt++; if (hi !== 32'h1234) begin err_cnt++; $display("FAIL mthi hi: got %h want 00001234", hi); end
    cmp_cnt++; if (lo !== 32'h0)    begin err_cnt++; $display("FAIL mthi lo: got %h want 0", lo); end
    lo_write = 1'b1; a = 32'h5678;
    @(posedge clk); #1;
    lo_write = 1'b0;
    cmp_cnt++; if (lo !== 32'h5678) begin err_cnt++; $display("FAIL mtlo lo: got %h want 00005678", lo); end
    cmp_cnt++; if (hi !== 32'h1234) begin err_cnt++; $display("FAIL mtlo hi: got %h want 00001234", hi); end
    hi_write = 1'b1; lo_write = 1'b1; a = 32'h9ABC;
    @(posedge clk); #1;
    hi_write = 1'b0; lo_write = 1'b0;
    cmp_cnt++; if (hi !== 32'h9ABC || lo !== 32'h9ABC) begin
      err_cnt++; $display("FAIL both write: got %h/%h want 00009abc/00009abc", hi, lo);
    end
    // start wins over writes presented in the same cycle
    start = 1'b1; is_div = 1'b0; sign = 1'b0; a = 32'd2; b = 32'd3; hi_write = 1'b1; lo_write = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    cmp_cnt++; if (hi !== 32'h9ABC || lo !== 32'h9ABC) begin
      err_cnt++; $display("FAIL start priority: got %h/%h want 00009abc/00009abc", hi, lo);
    end
    cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL start priority busy: got %b want 1", busy); end
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    cmp_cnt++; if (hi !== 32'h0 || lo !== 32'd6) begin
      err_cnt++; $display("FAIL start priority result: got %h/%h want 00000000/00000006", hi, lo);
    end
  endtask

  task automatic test_mul;
    vec_t v[4];
    logic [31:0] rh, rl;
    int lat;
    logic chg, dn;
    v[0] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[1] = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    v[2] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[3] = '{1'b0, 1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].d, v[i].s, v[i].av, v[i].bv, rh, rl, lat, chg, dn);
      cmp_cnt++; if (lat !== 34)      begin err_cnt++; $display("FAIL mul[%0d] latency: got %0d want 34", i, lat); end
      cmp_cnt++; if (rh !== v[i].eh) begin err_cnt++; $display("FAIL mul[%0d] hi: got %h want %h", i, rh, v[i].eh); end
      cmp_cnt++; if (rl !== v[i].el) begin err_cnt++; $display("FAIL mul[%0d] lo: got %h want %h", i, rl, v[i].el); end
      cmp_cnt++; if (chg !== 1'b0)   begin err_cnt++; $display("FAIL mul[%0d] early hilo change: got %b want 0", i, chg); end
      cmp_cnt++; if (dn !== 1'b0)    begin err_cnt++; $display("FAIL mul[%0d] done width: got %b want 0", i, dn); end
    end
  endtask

  task automatic test_div;
    vec_t v[8];
    logic [31:0] rh, rl;
    int lat;
    logic chg, dn;
    v[0] = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
    v[1] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[2] = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    v[3] = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC};
    v[4] = '{1'b1, 1'b0, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    v[5] = '{1'b1, 1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    v[6] = '{1'b1, 1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    v[7] = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].d, v[i].s, v[i].av, v[i].bv, rh, rl, lat, chg, dn);
      cmp_cnt++; if (lat !== 34)      begin err_cnt++; $display("FAIL div[%0d] latency: got %0d want 34", i, lat); end
      cmp_cnt++; if (rh !== v[i].eh) begin err_cnt++; $display("FAIL div[%0d] hi: got %h want %h", i, rh, v[i].eh); end
      cmp_cnt++; if (rl !== v[i].el) begin err_cnt++; $display("FAIL div[%0d] lo: got %h want %h", i, rl, v[i].el); end
      cmp_cnt++; if (chg !== 1'b0)   begin err_cnt++; $display("FAIL div[%0d] early hilo change: got %b want 0", i, chg); end
      cmp_cnt++; if (dn !== 1'b0)    begin err_cnt++; $display("FAIL div[%0d] done width: got %b want 0", i, dn); end
    end
  endtask

  task automatic test_stall;
    logic [31:0] h0;
    int n;
    @(posedge clk); #1;
    start = 1'b1; is_div = 1'b0; sign = 1'b0; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    h0 = hi;
    for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; end
    hi_write = 1'b1; hilo_read = 1'b1; a = 32'h1234;
    #1;
    cmp_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL busy stall: got %b want 1", stall); end
    @(posedge clk); #1;
    cmp_cnt++; if (hi !== h0) begin err_cnt++; $display("FAIL busy mthi dropped: got %h want %h", hi, h0); end
    hi_write = 1'b0; hilo_read = 1'b0;
    #1;
    cmp_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL busy no request stall: got %b want 0", stall); end
    start = 1'b1;
    #1;
    cmp_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL busy start stall: got %b want 1", stall); end
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    cmp_cnt++; if (n !== 24) begin err_cnt++; $display("FAIL stall op latency: got %0d want 24", n); end
    cmp_cnt++; if (hi !== 32'h0 || lo !== 32'd42) begin
      err_cnt++; $display("FAIL stall op result: got %h/%h want 00000000/0000002a", hi, lo);
    end
  endtask

  task automatic test_clr;
    logic [31:0] rh, rl;
    int lat, dcount;
    logic chg, dn;
    @(posedge clk); #1;
    hi_write = 1'b1; a = 32'h55;
    @(posedge clk); #1;
    hi_write = 1'b0;
    start = 1'b1; is_div = 1'b1; sign = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; end
    clr = 1'b1;
    #1;
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL clr busy: got %b want 0", busy); end
    cmp_cnt++; if (hi !== 32'h0 || lo !== 32'h0) begin
      err_cnt++; $display("FAIL clr hilo: got %h/%h want 0/0", hi, lo);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dcount++;
      @(posedge clk); #1;
    end
    cmp_cnt++; if (dcount !== 0) begin err_cnt++; $display("FAIL clr no done: got %0d pulses want 0", dcount); end
    run_op(1'b1, 1'b0, 32'd9, 32'd3, rh, rl, lat, chg, dn);
    cmp_cnt++; if (lat !== 34) begin err_cnt++; $display("FAIL post-clr latency: got %0d want 34", lat); end
    cmp_cnt++; if (rh !== 32'd0 || rl !== 32'd3) begin
      err_cnt++; $display("FAIL post-clr div: got %h/%h want 00000000/00000003", rh, rl);
    end
  endtask

  task automatic test_back_to_back;
    int n1, n2;
    @(posedge clk); #1;
    start = 1'b1; is_div = 1'b0; sign = 1'b0; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    cmp_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL b2b held stall: got %b want 1", stall); end
    n1 = 0;
    while (done !== 1'b1 && n1 < 100) begin @(posedge clk); #1; n1++; end
    cmp_cnt++; if (n1 !== 34) begin err_cnt++; $display("FAIL b2b first latency: got %0d want 34", n1); end
    cmp_cnt++; if (busy !== 1'b0 || stall !== 1'b0) begin
      err_cnt++; $display("FAIL b2b idle gap: got busy %b stall %b want 0 0", busy, stall);
    end
    cmp_cnt++; if (lo !== 32'd12) begin err_cnt++; $display("FAIL b2b first lo: got %h want 0000000c", lo); end
    @(posedge clk); #1;
    start = 1'b0;
    cmp_cnt++; if (busy !== 1'b1 || done !== 1'b0) begin
      err_cnt++; $display("FAIL b2b reissue: got busy %b done %b want 1 0", busy, done);
    end
    n2 = 0;
    while (done !== 1'b1 && n2 < 100) begin @(posedge clk); #1; n2++; end
    cmp_cnt++; if (n2 !== 34) begin err_cnt++; $display("FAIL b2b second latency: got %0d want 34", n2); end
    cmp_cnt++; if (hi !== 32'd0 || lo !== 32'd12) begin
      err_cnt++; $display("FAIL b2b second result: got %h/%h want 00000000/0000000c", hi, lo);
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; is_div = 1'b0; sign = 1'b0;
    hi_write = 1'b0; lo_write = 1'b0; hilo_read = 1'b0; a = '0; b = '0;
    test_reset;
    test_hilo_write;
    test_mul;
    test_div;
    test_stall;
    test_clr;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
